adc_page_streamer: RTL

- Reads the 48-bit IQ sample pages that the receiver writes into the dual-clock ADC RAM (2 pages × 128 words).
- Serialises each completed page into a framed byte stream for the FT232H transmit path in usb_control.
- Sits in the usb_clock domain, between the adc_ram read port and the usb_control byte arbiter.
- Detects page completion from the receiver's page flag, which arrives from the clock_76M domain.

---
 rtl/micron_pkg.sv | 20 ++
 rtl/cdc_sync_edge.sv | 29 ++
 rtl/adc_page_streamer.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/micron_pkg.sv
// Shared constants and state encoding for the ADC page streamer.
package micron_pkg;

  localparam logic [7:0]  SYNC0_DEFAULT  = 8'hAA;
  localparam logic [7:0]  SYNC1_DEFAULT  = 8'h55;
  localparam int unsigned BYTES_PER_WORD = 6;
  localparam int unsigned HDR_BYTES      = 3;

  typedef enum logic [2:0] {
    StIdle,
    StHdr0,
    StHdr1,
    StHdr2,
    StRd,
    StWait,
    StByte,
    StNext
  } stream_state_e;

endpackage

// File: rtl/cdc_sync_edge.sv
// Two-flop synchroniser for a slow level from another clock domain, plus a
// one-cycle pulse whenever the synchronised level changes.
module cdc_sync_edge (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic level_o,
  output logic pulse_o
);

  logic meta_q, sync_q, prev_q;

  // Synchroniser chain and a delayed copy for change detection.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign level_o = sync_q;
  assign pulse_o = sync_q ^ prev_q;

endmodule

// File: rtl/adc_page_streamer.sv
// Streams completed ADC RAM pages as framed bytes: SYNC0, SYNC1, seq, then
// each 48-bit word big-endian. One extra page may queue behind the active one.
module adc_page_streamer
  import micron_pkg::*;
#(
  parameter int unsigned WORDS_PER_PAGE = 128,
  parameter int unsigned RAM_LAT        = 2,
  parameter logic [7:0]  SYNC0          = SYNC0_DEFAULT,
  parameter logic [7:0]  SYNC1          = SYNC1_DEFAULT
) (
  input  logic        usb_clock,
  input  logic        m_reset,
  input  logic        enable,
  input  logic        adc_ram_block,
  input  logic [47:0] adc_ram_rd_data,
  output logic [7:0]  adc_ram_rd_addr,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        overrun,
  input  logic        clr_overrun
);

  stream_state_e state_q;
  logic [7:0]    addr_q, tx_data_q, seq_q;
  logic          tx_valid_q, busy_q, overrun_q;
  logic          pending_q, pend_page_q, page_q;
  logic [6:0]    word_idx_q;
  logic [3:0]    wait_cnt_q;
  logic [2:0]    byte_cnt_q;
  logic [47:0]   sreg_q;

  logic blk_level, blk_pulse;
  logic page_ready, ready_page;
  logic hs, last_word, frame_end;
  logic start_new, start_pend, start_frame, start_page, ovr_evt;

  cdc_sync_edge u_blk_sync (
    .clk_i   (usb_clock),
    .rst_ni  (m_reset),
    .d_i     (adc_ram_block),
    .level_o (blk_level),
    .pulse_o (blk_pulse)
  );

  // The page just finished is the one the receiver has moved away from.
  assign page_ready = blk_pulse & enable;
  assign ready_page = ~blk_level;

  assign hs        = tx_valid_q & tx_ready;
  assign last_word = (word_idx_q == 7'(WORDS_PER_PAGE - 1));
  assign frame_end = (state_q == StNext) & last_word;

  // A fresh page_ready at frame end with nothing queued starts immediately
  // rather than being parked as pending.
  assign start_new   = page_ready & ((state_q == StIdle) | (frame_end & ~pending_q));
  assign start_pend  = frame_end & pending_q;
  assign start_frame = start_new | start_pend;
  assign start_page  = start_new ? ready_page : pend_page_q;
  assign ovr_evt     = page_ready & pending_q;

  // Streamer FSM with registered outputs and page scheduling.
  always_ff @(posedge usb_clock or negedge m_reset) begin
    if (!m_reset) begin
      state_q     <= StIdle;
      addr_q      <= 8'h00;
      tx_data_q   <= 8'h00;
      tx_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
      seq_q       <= 8'h00;
      pending_q   <= 1'b0;
      pend_page_q <= 1'b0;
      page_q      <= 1'b0;
      word_idx_q  <= 7'd0;
      wait_cnt_q  <= 4'd0;
      byte_cnt_q  <= 3'd0;
      sreg_q      <= 48'h0;
    end else begin
      // A new loss event wins over a simultaneous clear.
      overrun_q <= (overrun_q & ~clr_overrun) | ovr_evt;
      if (!enable) begin
        state_q    <= StIdle;
        tx_valid_q <= 1'b0;
        busy_q     <= 1'b0;
        pending_q  <= 1'b0;
        seq_q      <= 8'h00;
        word_idx_q <= 7'd0;
      end else begin
        if (start_frame) begin
          state_q    <= StHdr0;
          page_q     <= start_page;
          word_idx_q <= 7'd0;
          tx_data_q  <= SYNC0;
          tx_valid_q <= 1'b1;
          busy_q     <= 1'b1;
        end else begin
          unique case (state_q)
            StIdle: ;
            StHdr0: if (hs) begin
              tx_data_q <= SYNC1;
              state_q   <= StHdr1;
            end
            StHdr1: if (hs) begin
              tx_data_q <= seq_q;
              state_q   <= StHdr2;
            end
            StHdr2: if (hs) begin
              tx_valid_q <= 1'b0;
              addr_q     <= {page_q, word_idx_q};
              state_q    <= StRd;
            end
            StRd: begin
              wait_cnt_q <= 4'd0;
              state_q    <= StWait;
            end
            StWait: begin
              if (wait_cnt_q == 4'(RAM_LAT - 1)) begin
                sreg_q     <= adc_ram_rd_data;
                tx_data_q  <= adc_ram_rd_data[47:40];
                tx_valid_q <= 1'b1;
                byte_cnt_q <= 3'd0;
                state_q    <= StByte;
              end else begin
                wait_cnt_q <= wait_cnt_q + 4'd1;
              end
            end
            StByte: if (hs) begin
              if (byte_cnt_q == 3'(BYTES_PER_WORD - 1)) begin
                tx_valid_q <= 1'b0;
                state_q    <= StNext;
              end else begin
                tx_data_q  <= sreg_q[39:32];
                sreg_q     <= {sreg_q[39:0], 8'h00};
                byte_cnt_q <= byte_cnt_q + 3'd1;
              end
            end
            StNext: begin
              if (last_word) begin
                busy_q  <= 1'b0;
                state_q <= StIdle;
              end else begin
                word_idx_q <= word_idx_q + 7'd1;
                addr_q     <= {page_q, word_idx_q + 7'd1};
                state_q    <= StRd;
              end
            end
            default: state_q <= StIdle;
          endcase
        end
        if (frame_end) seq_q <= seq_q + 8'd1;
        if (start_pend) pending_q <= 1'b0;
        // Queue (or replace) the next page; this overrides the clear above.
        if (page_ready && !start_new) begin
          pending_q   <= 1'b1;
          pend_page_q <= ready_page;
        end
      end
    end
  end

  assign adc_ram_rd_addr = addr_q;
  assign tx_data         = tx_data_q;
  assign tx_valid        = tx_valid_q;
  assign busy            = busy_q;
  assign overrun         = overrun_q;

endmodule
